alu_mult_seq: RTL and testbench

- Multi-cycle 16x16 multiply sequencer that borrows the shared 16-bit ALU, which performs every addition and negation; the block itself holds only shift and counter state.
- Sits beside the ALU in the execute stage. While busy is high, the upstream ALU input mux selects this block's alu_* outputs.
- Produces a 32-bit product, signed or unsigned, with fixed latency.

---
 rtl/alu_mult_seq_if.sv | 41 ++++
 rtl/alu_mult_seq.sv | 194 +++++++++++++++++++
 tb/tb_alu_mult_seq.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/alu_mult_seq_if.sv
// rtl/alu_mult_seq_if.sv - request/result and shared-ALU signal bundle for alu_mult_seq
//
// Groups the multiply request, the product result and the shared ALU drive/return
// signals. The sequencer connects through the slave modport. The execute stage
// (request source, result sink and shared ALU) connects through the master modport.
//   start, sign, op_a, op_b        : multiply request
//   busy, done, prod_hi, prod_lo   : status and 32-bit product
//   alu_a .. alu_sign              : operands/controls driven into the shared ALU
//   alu_out, alu_ofl               : same-cycle ALU result and carry-out

interface alu_mult_seq_if;
    logic        start;
    logic        sign;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        busy;
    logic        done;
    logic [15:0] prod_hi;
    logic [15:0] prod_lo;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_cin;
    logic [2:0]  alu_op;
    logic        alu_inva;
    logic        alu_invb;
    logic        alu_sign;
    logic [15:0] alu_out;
    logic        alu_ofl;

    modport slave (
        input  start, sign, op_a, op_b, alu_out, alu_ofl,
        output busy, done, prod_hi, prod_lo,
        output alu_a, alu_b, alu_cin, alu_op, alu_inva, alu_invb, alu_sign
    );

    modport master (
        output start, sign, op_a, op_b, alu_out, alu_ofl,
        input  busy, done, prod_hi, prod_lo,
        input  alu_a, alu_b, alu_cin, alu_op, alu_inva, alu_invb, alu_sign
    );
endinterface

// File: rtl/alu_mult_seq.sv
// rtl/alu_mult_seq.sv - 16x16 shift-add multiply sequencer that borrows the shared ALU
//
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : alu_mult_seq_if.slave
//          start/sign/op_a/op_b request, busy/done/prod_hi/prod_lo result,
//          alu_* drive into the shared ALU with alu_out/alu_ofl returned in the same cycle.
//
// Every addition and negation goes through the shared ALU. This block holds only the
// shift registers, the carry bit and the step counter. Signed operands are reduced to
// their magnitudes first. The 32-bit magnitude product is then negated one half at a time.
// The low-half carry feeds the high half.
// Latency is fixed: done comes 33 cycles after start (unsigned) or 37 cycles after start (signed).

module alu_mult_seq (
    input  logic           clk,
    input  logic           rst,
    alu_mult_seq_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_NEG_A,
        S_NEG_B,
        S_ADD,
        S_SHIFT,
        S_NEG_LO,
        S_NEG_HI,
        S_DONE
    } state_t;

    state_t      state;
    logic [15:0] mcand;     // multiplicand (magnitude once NEG_A has run)
    logic [15:0] mplr;      // multiplier, shifted out as product low half shifts in
    logic [15:0] acc;       // product high half
    logic        c;         // ADD carry-out, or low-half negation carry
    logic [4:0]  cnt;
    logic        neg_a;
    logic        neg_b;
    logic        sgn_r;
    logic        busy_r;
    logic        done_r;
    logic [15:0] prod_hi_r;
    logic [15:0] prod_lo_r;

    logic        neg;
    logic [15:0] drv_a;
    logic [15:0] drv_b;
    logic        drv_cin;
    logic        drv_invb;

    assign neg = neg_a ^ neg_b;

    // ALU drive is decoded from the registered state. The ALU result is consumed at the
    // same edge, so the drive has to track the current state.
    // Negation is ~x + 1, using invb together with cin.
    always_comb begin
        drv_a    = 16'h0000;
        drv_b    = 16'h0000;
        drv_cin  = 1'b0;
        drv_invb = 1'b0;
        case (state)
            S_NEG_A: begin
                drv_b    = mcand;
                drv_invb = neg_a;
                drv_cin  = neg_a;
            end
            S_NEG_B: begin
                drv_b    = mplr;
                drv_invb = neg_b;
                drv_cin  = neg_b;
            end
            S_ADD: begin
                drv_a = acc;
                drv_b = mplr[0] ? mcand : 16'h0000;
            end
            S_NEG_LO: begin
                drv_b    = mplr;
                drv_invb = neg;
                drv_cin  = neg;
            end
            S_NEG_HI: begin
                // The +1 of the 32-bit negation reaches the high half only through the
                // carry out of the low half.
                drv_b    = acc;
                drv_invb = neg;
                drv_cin  = neg & c;
            end
            default: ;
        endcase
    end

    assign bus.alu_a    = drv_a;
    assign bus.alu_b    = drv_b;
    assign bus.alu_cin  = drv_cin;
    assign bus.alu_invb = drv_invb;
    assign bus.alu_op   = 3'b100;
    assign bus.alu_inva = 1'b0;
    assign bus.alu_sign = 1'b0;

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.prod_hi = prod_hi_r;
    assign bus.prod_lo = prod_lo_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            mcand     <= 16'h0000;
            mplr      <= 16'h0000;
            acc       <= 16'h0000;
            c         <= 1'b0;
            cnt       <= 5'd0;
            neg_a     <= 1'b0;
            neg_b     <= 1'b0;
            sgn_r     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            prod_hi_r <= 16'h0000;
            prod_lo_r <= 16'h0000;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        mcand  <= bus.op_a;
                        mplr   <= bus.op_b;
                        acc    <= 16'h0000;
                        c      <= 1'b0;
                        cnt    <= 5'd0;
                        sgn_r  <= bus.sign;
                        neg_a  <= bus.sign & bus.op_a[15];
                        neg_b  <= bus.sign & bus.op_b[15];
                        busy_r <= 1'b1;
                        state  <= bus.sign ? S_NEG_A : S_ADD;
                    end
                end
                S_NEG_A: begin
                    mcand <= bus.alu_out;
                    state <= S_NEG_B;
                end
                S_NEG_B: begin
                    mplr  <= bus.alu_out;
                    state <= S_ADD;
                end
                S_ADD: begin
                    acc   <= bus.alu_out;
                    c     <= bus.alu_ofl;
                    state <= S_SHIFT;
                end
                S_SHIFT: begin
                    {c, acc, mplr} <= {1'b0, c, acc, mplr[15:1]};
                    cnt            <= cnt + 5'd1;
                    if (cnt == 5'd15) begin
                        if (sgn_r) begin
                            state <= S_NEG_LO;
                        end else begin
                            // Unsigned: publish the post-shift product directly.
                            state     <= S_DONE;
                            busy_r    <= 1'b0;
                            done_r    <= 1'b1;
                            prod_hi_r <= {c, acc[15:1]};
                            prod_lo_r <= {acc[0], mplr[15:1]};
                        end
                    end else begin
                        state <= S_ADD;
                    end
                end
                S_NEG_LO: begin
                    mplr  <= bus.alu_out;
                    c     <= bus.alu_ofl;
                    state <= S_NEG_HI;
                end
                S_NEG_HI: begin
                    acc       <= bus.alu_out;
                    state     <= S_DONE;
                    busy_r    <= 1'b0;
                    done_r    <= 1'b1;
                    prod_hi_r <= bus.alu_out;
                    prod_lo_r <= mplr;
                end
                S_DONE: begin
                    // A start presented here is dropped. The earliest restart is in IDLE.
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mult_seq.sv
// tb/tb_alu_mult_seq.sv - self-checking bench for alu_mult_seq with a behavioural shared ALU

module tb_alu_mult_seq;

    logic clk;
    logic rst;

    alu_mult_seq_if bus ();

    alu_mult_seq u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Shared ALU: ADD with optional operand inversion and carry-in, unsigned carry-out.
    logic [16:0] alu_sum;
    assign alu_sum = {1'b0, (bus.alu_inva ? ~bus.alu_a : bus.alu_a)}
                   + {1'b0, (bus.alu_invb ? ~bus.alu_b : bus.alu_b)}
                   + {16'h0000, bus.alu_cin};
    assign bus.alu_out = alu_sum[15:0];
    assign bus.alu_ofl = alu_sum[16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_fail;

    typedef struct {
        logic        sign;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] prod;
    } vec_t;

    vec_t vecs [13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic launch(input logic s, input logic [15:0] a, input logic [15:0] b);
        bus.sign  = s;
        bus.op_a  = a;
        bus.op_b  = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Called in cycle c0. Returns the cycle in which done is seen (or -1), the product,
    // and the number of cycles before done in which busy was low.
    task automatic wait_done(input int c0, output logic [31:0] p, output int lat,
                             output int busy_bad);
        lat      = -1;
        busy_bad = 0;
        p        = 32'h0;
        for (int c = c0; c <= 60; c++) begin
            if (bus.done) begin
                lat = c;
                p   = {bus.prod_hi, bus.prod_lo};
                break;
            end
            if (!bus.busy) busy_bad++;
            tick();
        end
    endtask

    logic [31:0] p;
    int          lat;
    int          busy_bad;
    int          ndone;

    initial begin
        n_vec  = 0;
        n_fail = 0;

        vecs[0]  = '{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001};
        vecs[1]  = '{1'b1, 16'hFFFD, 16'h0005, 32'hFFFFFFF1};
        vecs[2]  = '{1'b1, 16'h8000, 16'h8000, 32'h40000000};
        vecs[3]  = '{1'b1, 16'h0000, 16'hFFFF, 32'h00000000};
        vecs[4]  = '{1'b0, 16'h1234, 16'h0002, 32'h00002468};
        vecs[5]  = '{1'b0, 16'h0007, 16'h0006, 32'h0000002A};
        vecs[6]  = '{1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001};
        vecs[7]  = '{1'b1, 16'h7FFF, 16'h8000, 32'hC0008000};
        vecs[8]  = '{1'b0, 16'h8000, 16'h8000, 32'h40000000};
        vecs[9]  = '{1'b1, 16'h0003, 16'hFFFE, 32'hFFFFFFFA};
        vecs[10] = '{1'b0, 16'h0000, 16'h1234, 32'h00000000};
        vecs[11] = '{1'b1, 16'h8000, 16'h0001, 32'hFFFF8000};
        vecs[12] = '{1'b0, 16'h00FF, 16'h0100, 32'h0000FF00};

        bus.start = 1'b0;
        bus.sign  = 1'b0;
        bus.op_a  = 16'h0;
        bus.op_b  = 16'h0;
        rst       = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_done", {31'b0, bus.done}, 32'd0);
        chk("rst_prod", {bus.prod_hi, bus.prod_lo}, 32'h0);
        chk("rst_alu_op", {29'b0, bus.alu_op}, 32'd4);
        chk("rst_alu_ab", {bus.alu_a, bus.alu_b}, 32'h0);
        chk("rst_alu_ctl", {29'b0, bus.alu_cin, bus.alu_invb, bus.alu_inva}, 32'd0);

        // Table-driven products with latency and busy coverage
        foreach (vecs[i]) begin
            launch(vecs[i].sign, vecs[i].a, vecs[i].b);
            wait_done(1, p, lat, busy_bad);
            chk($sformatf("v%0d_prod", i), p, vecs[i].prod);
            chk($sformatf("v%0d_lat", i), lat, vecs[i].sign ? 32'd37 : 32'd33);
            chk($sformatf("v%0d_busy", i), busy_bad, 32'd0);
            chk($sformatf("v%0d_busy_at_done", i), {31'b0, bus.busy}, 32'd0);
            tick();
            chk($sformatf("v%0d_done_pulse", i), {31'b0, bus.done}, 32'd0);
            chk($sformatf("v%0d_prod_hold", i), {bus.prod_hi, bus.prod_lo}, vecs[i].prod);
        end

        // NEG_A drive for a negative multiplicand
        launch(1'b1, 16'hFFFD, 16'h0005);
        chk("nega_alu_a", {16'h0, bus.alu_a}, 32'h0);
        chk("nega_alu_b", {16'h0, bus.alu_b}, 32'h0000FFFD);
        chk("nega_invb_cin", {30'b0, bus.alu_invb, bus.alu_cin}, 32'd3);
        tick();
        wait_done(2, p, lat, busy_bad);
        chk("nega_prod", p, 32'hFFFFFFF1);
        chk("nega_lat", lat, 32'd37);
        tick();

        // Start ignored while busy and in the DONE cycle
        ndone = 0;
        lat   = -1;
        launch(1'b0, 16'h1234, 16'h0002);
        for (int c = 1; c <= 40; c++) begin
            if (bus.done) begin
                ndone++;
                lat = c;
                p   = {bus.prod_hi, bus.prod_lo};
            end
            bus.start = (c == 5) || (c == 33);
            bus.op_a  = (c == 5) ? 16'h7777 : 16'h1234;
            if (c == 34) chk("done_start_ignored", {31'b0, bus.busy}, 32'd0);
            tick();
            bus.start = 1'b0;
        end
        chk("ign_ndone", ndone, 32'd1);
        chk("ign_lat", lat, 32'd33);
        chk("ign_prod", p, 32'h00002468);
        chk("ign_idle", {31'b0, bus.busy}, 32'd0);

        // Reset mid-operation
        launch(1'b1, 16'hFFFD, 16'h0005);
        for (int c = 1; c < 10; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", {31'b0, bus.busy}, 32'd0);
        chk("midrst_done", {31'b0, bus.done}, 32'd0);
        chk("midrst_prod", {bus.prod_hi, bus.prod_lo}, 32'h0);
        chk("midrst_alu_op", {29'b0, bus.alu_op}, 32'd4);
        chk("midrst_alu_ab", {bus.alu_a, bus.alu_b}, 32'h0);
        chk("midrst_alu_ctl", {29'b0, bus.alu_cin, bus.alu_invb, bus.alu_inva}, 32'd0);
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.done) ndone++;
            tick();
        end
        chk("midrst_no_done", ndone, 32'd0);
        launch(1'b0, 16'h0007, 16'h0006);
        wait_done(1, p, lat, busy_bad);
        chk("midrst_new_prod", p, 32'h0000002A);
        chk("midrst_new_lat", lat, 32'd33);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
